imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Sequencer in front of the instruction memory. After reset it streams a program into the memory through a loader handshake, then runs the fetch loop: it drives the word address, registers the instruction and PC for the decode stage, and honours pipeline stalls and branch/jump redirects. An illegal PC drives it into a sticky fault state. It sits between the memory (combinational read, synchronous write) and the IF/ID boundary of the MIPS core.

## Interface
- `SIZE`, 32: instruction memory depth in words.
- `RESET_PC`, 32'h0: first fetch address after load; word aligned.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `load_valid` in 1: loader word available.
- `load_last` in 1: qualifies `load_valid`; this word ends the program.
- `load_data` in 32: program word.
- `load_ready` out 1: controller accepts a loader word this cycle.
- `stall` in 1: decode cannot accept; hold the IF outputs and the PC.
- `redirect` in 1: branch/jump taken; squash and refetch.
- `redirect_pc` in 32: target byte address.
- `mem_addr` out 32: byte address to memory; word index = `mem_addr>>2`.
- `mem_we` out 1: memory write strobe.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: combinational read data at `mem_addr`.
- `if_valid` out 1: the IF outputs hold a live instruction.
- `if_inst` out 32: registered instruction.
- `if_pc` out 32: address of `if_inst`.
- `fault` out 1: sticky illegal-PC flag.

## Operation
- States:
  - LOAD: program load.
  - RUN: fetch loop.
  - FAULT: halted on an illegal PC.
- Reset enters LOAD.
- LOAD:
  - `load_ready`=1.
  - `mem_addr`=`ld_ptr<<2`, `mem_wdata`=`load_data`, `mem_we`=`load_valid`.
  - Each accepted word increments `ld_ptr`.
  - Go to RUN on an accepted word with `load_last`=1, or on an accepted word at `ld_ptr`=SIZE-1. `ld_ptr` never wraps.
  - Entering RUN sets `pc`=RESET_PC.
- RUN:
  - `mem_addr`=`pc`, `mem_we`=0, `load_ready`=0.
  - Priority per cycle: redirect > stall > advance.
  - redirect:
    - `if_valid`<=0 and `pc`<=`redirect_pc`.
    - If `redirect_pc[1:0]`≠0 or `redirect_pc>>2`≥SIZE, go to FAULT.
  - stall (without redirect): the IF registers and `pc` hold.
  - advance:
    - `if_inst`<=`mem_rdata`, `if_pc`<=`pc`, `if_valid`<=1.
    - `pc`<=`pc`+4, a 32-bit add with no saturation.
    - If the new `pc>>2`≥SIZE, go to FAULT. The last valid instruction is still presented.
- FAULT:
  - `fault`=1, `if_valid`=0, `mem_we`=0, `load_ready`=0.
  - Held until reset; `stall` and `redirect` are ignored.
- `mem_wdata` is 0 outside LOAD.

## Timing
- Reset values:
  - `pc`=RESET_PC, `ld_ptr`=0.
  - `if_valid`=0, `if_inst`=0, `if_pc`=0, `fault`=0.
  - `mem_we`=0, `mem_wdata`=0, `mem_addr`=0.
  - `load_ready`=1 (LOAD).
- Fetch latency: one cycle from `pc` to `if_inst`. The first `if_valid` appears on the second edge after LOAD exits.
- Throughput in RUN: one instruction per cycle without stall.
- Loader handshake: transfer when `load_valid`&&`load_ready` on an edge. The write lands on the same edge.
- Redirect to the first valid instruction at the target: two edges (one squash bubble).
- Reset mid-load: the memory contents stay partial; the pointer restarts at 0.

## Configuration
- `IMEM_BOOT_LOAD_EN` defined: LOAD state present, as above.
- Not defined:
  - Reset enters RUN directly at RESET_PC.
  - `load_ready`, `mem_we`, `mem_wdata` are tied to 0; the load inputs are ignored.
  - The memory is preinitialised by other means.

## Structure
- Shared package `mips_pkg`:
  - state enum `fetch_state_t` {LOAD, RUN, FAULT};
  - `INST_W`=32;
  - `PC_STEP`=4.
- Sub-module `imem_loader`, natural split: owns `ld_ptr`, the handshake, the write strobe and the done pulse. The top holds the FSM, PC and IF registers.

## Test plan
- Load three words A,B,C, `load_last` on C: memory words 0..2 written, then RUN; `if_inst`=A,B,C on consecutive cycles with `if_pc`=0,4,8.
- `stall` held 2 cycles while `if_pc`=4: `if_inst`/`if_pc` frozen 2 cycles, then `if_pc`=8.
- `redirect` with `redirect_pc`=0x10 at the same time as `stall`: redirect wins; one bubble (`if_valid`=0), then `if_pc`=0x10.
- `redirect_pc`=0x6: FAULT next cycle; `fault`=1, `if_valid`=0; stays there under further redirects until reset.
- Load SIZE words without `load_last`: auto-exit to RUN after word SIZE-1. Then run straight through: after `if_pc`=4*(SIZE-1), `fault`=1.
- Assert reset mid-load after 2 words, then reload 1 word with `load_last`: `ld_ptr` restarts at 0, the first fetch returns the new word 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS instruction-fetch slice.
//   fetch_state_t : fetch sequencer state (LOAD, RUN, FAULT)
//   INST_W        : instruction / data word width
//   PC_STEP       : byte increment between sequential instructions
//   pc_illegal()  : true for a PC that is unaligned or beyond the memory depth
package mips_pkg;

  localparam int unsigned INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  function automatic logic pc_illegal(input logic [31:0] pc, input int unsigned size);
    return (pc[1:0] != 2'b00) || ((pc >> 2) >= size);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams program words into the instruction memory.
// Owns the load pointer, the valid/ready handshake, the write strobe and
// the end-of-load pulse. Outputs are quiet (ready/we/wdata = 0) unless
// active_i is high.
//   clk, rst_n      : clock, asynchronous active-low reset
//   active_i        : controller is in its load phase
//   load_valid_i    : loader word available
//   load_last_i     : the offered word ends the program
//   load_data_i     : program word
//   load_ready_o    : word accepted this cycle when load_valid_i is high
//   mem_we_o        : memory write strobe
//   mem_wdata_o     : memory write data
//   mem_addr_o      : byte address of the word being written
//   done_o          : last word accepted this cycle
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active_i,
  input  logic              load_valid_i,
  input  logic              load_last_i,
  input  logic [INST_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              mem_we_o,
  output logic [INST_W-1:0] mem_wdata_o,
  output logic [31:0]       mem_addr_o,
  output logic              done_o
);

  localparam int unsigned PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [PTR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic             accept;
  logic             last_slot;

  assign accept    = active_i && load_valid_i;
  assign last_slot = (ld_ptr_q == PTR_W'(SIZE - 1));

  // The pointer saturates at the final slot; filling it ends the load.
  always_comb begin
    ld_ptr_d = ld_ptr_q;
    if (accept && !last_slot) begin
      ld_ptr_d = ld_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr_q <= '0;
    end else begin
      ld_ptr_q <= ld_ptr_d;
    end
  end

  assign load_ready_o = active_i;
  assign mem_we_o     = accept;
  assign mem_wdata_o  = active_i ? load_data_i : '0;
  assign mem_addr_o   = 32'(ld_ptr_q) << 2;
  assign done_o       = accept && (load_last_i || last_slot);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-memory sequencer feeding the IF/ID boundary.
// After reset it loads a program through the loader handshake, then fetches
// one instruction per cycle, honouring stalls and branch/jump redirects.
// An illegal PC (unaligned or beyond SIZE words) halts it in a sticky fault.
// Build option: define IMEM_BOOT_LOAD_EN to include the boot-load phase;
// otherwise reset enters the fetch loop directly and the load port is idle.
//   clk, reset          : clock, asynchronous active-low reset
//   load_valid/last/data: loader word stream; load_ready accepts a word
//   stall               : decode cannot accept, hold IF outputs and PC
//   redirect/redirect_pc: taken branch/jump, squash and refetch at target
//   mem_addr/we/wdata   : memory address (bytes) and write port
//   mem_rdata           : combinational read data at mem_addr
//   if_valid/inst/pc    : registered instruction for decode
//   fault               : sticky illegal-PC flag
module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned SIZE     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [INST_W-1:0] load_data,
  output logic              load_ready,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [INST_W-1:0] mem_wdata,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  output logic              fault
);

`ifdef IMEM_BOOT_LOAD_EN
  localparam fetch_state_t BOOT_STATE = LOAD;
`else
  localparam fetch_state_t BOOT_STATE = RUN;
`endif

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [31:0]       if_pc_q, if_pc_d;
  logic [31:0]       pc_adv;

  logic              ld_active;
  logic              ld_done;
  logic [31:0]       ld_addr;

  // Without the boot-load option the loader is never activated, so its
  // ready/strobe/data outputs stay at zero and the load inputs are ignored.
`ifdef IMEM_BOOT_LOAD_EN
  assign ld_active = (state_q == LOAD);
`else
  assign ld_active = 1'b0;
`endif

  imem_loader #(
    .SIZE (SIZE)
  ) u_loader (
    .clk          (clk),
    .rst_n        (reset),
    .active_i     (ld_active),
    .load_valid_i (load_valid),
    .load_last_i  (load_last),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_addr_o   (ld_addr),
    .done_o       (ld_done)
  );

  assign pc_adv = pc_q + PC_STEP;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      LOAD: begin
        if (ld_done) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          pc_d       = redirect_pc;
          if (pc_illegal(redirect_pc, SIZE)) begin
            state_d = FAULT;
          end
        end else if (!stall) begin
          if_inst_d  = mem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_adv;
          if (pc_illegal(pc_adv, SIZE)) begin
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT_STATE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Falling off the end of memory still captures the final instruction in
  // if_inst/if_pc; only the valid flag is suppressed once faulted.
  assign if_valid = if_valid_q && (state_q != FAULT);
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  assign fault    = (state_q == FAULT);
  assign mem_addr = (state_q == LOAD) ? ld_addr : pc_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  localparam int unsigned SIZE     = 16;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IMEM_BOOT_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        fault;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .SIZE     (SIZE),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .fault       (fault)
  );

  // Instruction memory: combinational read, synchronous write.
  logic [31:0] mem [SIZE];
  int unsigned rd_idx;
  always_comb begin
    rd_idx    = mem_addr >> 2;
    mem_rdata = (rd_idx < SIZE) ? mem[rd_idx] : 32'hDEADBEEF;
  end
  always @(posedge clk) begin
    if (mem_we && ((mem_addr >> 2) < SIZE)) mem[mem_addr >> 2] <= mem_wdata;
  end

  // Reference model: what the program image and the IF outputs should be.
  logic [31:0] exp_img [SIZE];
  bit          m_loading, m_fault, m_valid;
  int unsigned m_ptr;
  logic [31:0] m_pc, m_inst, m_ifpc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad_pc(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= SIZE);
  endfunction

  task automatic model_reset();
    m_loading = LOAD_EN;
    m_fault   = 1'b0;
    m_valid   = 1'b0;
    m_ptr     = 0;
    m_pc      = RESET_PC;
    m_inst    = '0;
    m_ifpc    = '0;
  endtask

  // One rising edge of behaviour, from the current inputs.
  task automatic model_edge();
    if (m_loading) begin
      if (load_valid) begin
        exp_img[m_ptr] = load_data;
        if (load_last || m_ptr == SIZE - 1) begin
          m_loading = 1'b0;
          m_pc      = RESET_PC;
        end else begin
          m_ptr++;
        end
      end
    end else if (!m_fault) begin
      if (redirect) begin
        m_valid = 1'b0;
        m_pc    = redirect_pc;
        if (bad_pc(redirect_pc)) m_fault = 1'b1;
      end else if (!stall) begin
        m_inst  = (m_pc / 4 < SIZE) ? exp_img[m_pc / 4] : 32'hDEADBEEF;
        m_ifpc  = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
        if (m_pc / 4 >= SIZE) m_fault = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("if_valid",   if_valid,   m_valid && !m_fault);
    chk("fault",      fault,      m_fault);
    chk("if_inst",    if_inst,    m_inst);
    chk("if_pc",      if_pc,      m_ifpc);
    chk("load_ready", load_ready, m_loading);
    chk("mem_we",     mem_we,     m_loading && load_valid);
    chk("mem_wdata",  mem_wdata,  m_loading ? load_data : 32'h0);
    if (!m_fault) chk("mem_addr", mem_addr, m_loading ? m_ptr * 4 : m_pc);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    load_valid  = 1'b0;
    load_last   = 1'b0;
    load_data   = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #2;
    reset = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] last_word;

  // Offers n words with random idle gaps; stall/redirect toggle meanwhile
  // and must be ignored during the load.
  task automatic load_seq(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        load_valid  = 1'b0;
        load_last   = 1'($urandom_range(0, 1));
        load_data   = $urandom;
        stall       = 1'($urandom_range(0, 1));
        redirect    = 1'($urandom_range(0, 1));
        redirect_pc = $urandom;
        tick();
      end
      load_valid = 1'b1;
      load_data  = $urandom;
      last_word  = load_data;
      load_last  = with_last && (i == n - 1);
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      mem[i]     = $urandom;
      exp_img[i] = mem[i];
    end

    // Load three words, stream them, stall, redirect, fault.
    do_reset();
    if (LOAD_EN) load_seq(3, 1'b1);
    tick();
    chk("t1_valid0", if_valid, 1'b1);
    chk("t1_inst0",  if_inst,  exp_img[0]);
    chk("t1_pc0",    if_pc,    32'h0);
    tick();
    chk("t1_inst1",  if_inst,  exp_img[1]);
    chk("t1_pc1",    if_pc,    32'h4);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t1_stall_pc",   if_pc,   32'h4);
      chk("t1_stall_inst", if_inst, exp_img[1]);
    end
    stall = 1'b0;
    tick();
    chk("t1_pc2",   if_pc,   32'h8);
    chk("t1_inst2", if_inst, exp_img[2]);
    redirect = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
    tick();
    chk("t1_bubble", if_valid, 1'b0);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("t1_redir_valid", if_valid, 1'b1);
    chk("t1_redir_pc",    if_pc,    32'h10);
    chk("t1_redir_inst",  if_inst,  exp_img[4]);
    redirect = 1'b1; redirect_pc = 32'h6;
    tick();
    chk("t1_fault",     fault,    1'b1);
    chk("t1_fault_val", if_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      redirect    = 1'($urandom_range(0, 1));
      stall       = 1'($urandom_range(0, 1));
      redirect_pc = {26'($urandom_range(0, SIZE - 1)), 2'b00};
      tick();
      chk("t1_sticky", fault, 1'b1);
    end

    // Fill the whole memory without load_last, then run off the end.
    do_reset();
    if (LOAD_EN) begin
      load_seq(SIZE, 1'b0);
      chk("t2_autoexit", load_ready, 1'b0);
    end
    for (int c = 0; c < 4 * SIZE && !m_fault; c++) tick();
    chk("t2_fault",   fault,   1'b1);
    chk("t2_last_pc", if_pc,   4 * (SIZE - 1));
    chk("t2_last_in", if_inst, exp_img[SIZE - 1]);
    chk("t2_valid",   if_valid, 1'b0);

    // Reset during a load: pointer restarts, earlier words stay.
    if (LOAD_EN) begin
      do_reset();
      load_seq(2, 1'b0);
      do_reset();
      load_seq(1, 1'b1);
      tick();
      chk("t3_newword", if_inst, last_word);
      chk("t3_pc",      if_pc,   32'h0);
      tick();
      chk("t3_partial", if_inst, exp_img[1]);
    end

    // Randomized runs.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      if (LOAD_EN) begin
        int n;
        n = $urandom_range(1, SIZE + 2);
        load_seq(n, (n < SIZE) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      for (int c = 0; c < 40; c++) begin
        stall       = ($urandom_range(0, 9) < 3);
        redirect    = ($urandom_range(0, 9) == 0);
        redirect_pc = ($urandom_range(0, 4) != 0) ?
                      {26'($urandom_range(0, SIZE - 1)), 2'b00} : $urandom;
        load_valid  = 1'($urandom_range(0, 1));
        load_last   = 1'($urandom_range(0, 1));
        load_data   = $urandom;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
